// File: rtl/ctx_mem_pkg.sv
// Shared types for the context-memory interface: address/word types,
// the read-response record and the poison word returned on bad reads.
package ctx_mem_pkg;

    typedef logic [31:0] ctx_addr_t;
    typedef logic [31:0] ctx_word_t;

    typedef struct packed {
        logic      valid;
        logic      err;
        ctx_word_t data;
    } ctx_rsp_t;

    localparam ctx_word_t CTX_POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/ctx_mem_rsp_pipe.sv
// Fixed-latency response pipeline: stage 0 loads every cycle, the last
// stage drives the response. Shared with the instruction-side memory model.
module ctx_mem_rsp_pipe
    import ctx_mem_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  ctx_rsp_t rsp_i,
    output ctx_rsp_t rsp_o
);

    ctx_rsp_t r_stage [RD_LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(RD_LATENCY); k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= rsp_i;
            for (int k = 1; k < int'(RD_LATENCY); k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign rsp_o = r_stage[RD_LATENCY-1];

endmodule

// File: rtl/ctx_mem_responder.sv
// Memory-side endpoint of the RTOS-unit context memory interface.
// Optional statistics counters are enabled with CTX_MEM_RESPONDER_STATS_EN.
module ctx_mem_responder
    import ctx_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter ctx_addr_t   BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ctx_mem_wr_en_i,
    input  logic [31:0] ctx_mem_wr_addr_i,
    input  logic [31:0] ctx_mem_wr_data_i,
    input  logic        ctx_mem_rd_rq_valid_i,
    input  logic [31:0] ctx_mem_rd_rq_addr_i,
`ifdef CTX_MEM_RESPONDER_STATS_EN
    input  logic             stat_clr_i,
    output logic [CNT_W-1:0] stat_wr_cnt_o,
    output logic [CNT_W-1:0] stat_rd_cnt_o,
    output logic [CNT_W-1:0] stat_err_cnt_o,
`endif
    output logic        ctx_mem_rd_resp_valid_o,
    output logic [31:0] ctx_mem_rd_data_o,
    output logic        ctx_mem_err_o
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam ctx_addr_t   STORE_BYTES = 32'(DEPTH * 4);

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $error("RD_LATENCY must be in 1..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    ctx_addr_t          w_wr_off;
    ctx_addr_t          w_rd_off;
    logic               w_wr_hit;
    logic               w_rd_hit;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    ctx_rsp_t           w_rsp_in;
    ctx_rsp_t           w_rsp_out;
    logic               w_rd_err;
    ctx_word_t          r_mem [DEPTH];
    logic               r_wr_err;

    // Unsigned offset wraps below BASE_ADDR, so one compare covers both bounds.
    assign w_wr_off = ctx_mem_wr_addr_i - BASE_ADDR;
    assign w_rd_off = ctx_mem_rd_rq_addr_i - BASE_ADDR;
    assign w_wr_hit = (w_wr_off < STORE_BYTES);
    assign w_rd_hit = (w_rd_off < STORE_BYTES);
    assign w_wr_idx = w_wr_off[IDX_W+1:2];
    assign w_rd_idx = w_rd_off[IDX_W+1:2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (ctx_mem_wr_en_i && w_wr_hit) begin
            r_mem[w_wr_idx] <= ctx_mem_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= ctx_mem_wr_en_i && !w_wr_hit;
        end
    end

    // Read sample with write-first bypass for a same-cycle write to the same word.
    always_comb begin
        w_rsp_in = '0;
        if (ctx_mem_rd_rq_valid_i) begin
            w_rsp_in.valid = 1'b1;
            if (!w_rd_hit) begin
                w_rsp_in.err  = 1'b1;
                w_rsp_in.data = CTX_POISON;
            end else if (ctx_mem_wr_en_i && w_wr_hit && (w_wr_idx == w_rd_idx)) begin
                w_rsp_in.data = ctx_mem_wr_data_i;
            end else begin
                w_rsp_in.data = r_mem[w_rd_idx];
            end
        end
    end

    ctx_mem_rsp_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rsp_i (w_rsp_in),
        .rsp_o (w_rsp_out)
    );

    assign w_rd_err                = w_rsp_out.valid && w_rsp_out.err;
    assign ctx_mem_rd_resp_valid_o = w_rsp_out.valid;
    assign ctx_mem_rd_data_o       = w_rsp_out.data;
    assign ctx_mem_err_o           = r_wr_err || w_rd_err;

`ifdef CTX_MEM_RESPONDER_STATS_EN
    logic [CNT_W-1:0] r_stat_wr;
    logic [CNT_W-1:0] r_stat_rd;
    logic [CNT_W-1:0] r_stat_err;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Errors are counted when they pulse, so a write/read collision adds two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else if (stat_clr_i) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else begin
            r_stat_wr  <= sat_add(r_stat_wr, {1'b0, ctx_mem_wr_en_i && w_wr_hit});
            r_stat_rd  <= sat_add(r_stat_rd, {1'b0, ctx_mem_rd_rq_valid_i});
            r_stat_err <= sat_add(r_stat_err, {1'b0, r_wr_err} + {1'b0, w_rd_err});
        end
    end

    assign stat_wr_cnt_o  = r_stat_wr;
    assign stat_rd_cnt_o  = r_stat_rd;
    assign stat_err_cnt_o = r_stat_err;
`endif

endmodule

// File: doc/ctx_mem_responder.md
Name: ctx_mem_responder

Overview:
- Memory-side endpoint of the RTOS-unit context memory interface.
- Services the unit's word writes and read requests, and returns read data after a fixed, parameterised latency.
- Sits between the core/RTOS-unit wrapper and the simulation/SoC fabric and owns a dedicated context-save word store.
- The interface has no backpressure, so the block must accept every request in the cycle it is presented.

Parameters:
- DEPTH, 1024, number of 32-bit words in the context store (power of two).
- BASE_ADDR, 32'h0001_0000, byte base address of the store (DEPTH*4-aligned).
- RD_LATENCY, 2, cycles from read-request acceptance to response valid (legal range 1..8).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- ctx_mem_wr_en_i  in  1  write strobe; one word written per cycle when high.
- ctx_mem_wr_addr_i  in  32  write byte address.
- ctx_mem_wr_data_i  in  32  write data.
- ctx_mem_rd_rq_valid_i  in  1  read request strobe.
- ctx_mem_rd_rq_addr_i  in  32  read byte address.
- ctx_mem_rd_resp_valid_o  out  1  one-cycle pulse per response.
- ctx_mem_rd_data_o  out  32  response data; valid only while resp_valid is high.
- ctx_mem_err_o  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset:
  - Store, pipeline and all outputs go to 0 immediately on rst_i and stay there until rst_i deasserts.
  - Requests in flight are discarded; no response is emitted for them.
- Address decode:
  - idx = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] is ignored.
  - In range: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH, with the subtraction done as 32-bit unsigned.
- Write:
  - wr_en high and in range: store[idx] <= wdata at the clock edge.
  - wr_en high and out of range: write dropped; ctx_mem_err_o pulses the next cycle.
- Read:
  - Each rd_rq_valid high cycle is accepted unconditionally.
  - Data is sampled from the store at acceptance and pushed into a RD_LATENCY-stage pipeline of {valid, err, data}.
  - The response appears exactly RD_LATENCY cycles after the request cycle.
  - Back-to-back requests give back-to-back responses, in order; throughput is 1 per cycle.
- Read-after-write ordering:
  - A read accepted in the same cycle as a write to the same idx returns the new write data (write-first bypass).
  - A write issued after read acceptance does not affect that read's returned data.
- Out-of-range read:
  - The response is still issued on schedule with data 32'hDEAD_BEEF.
  - ctx_mem_err_o pulses in the same cycle as that response.
- Error collisions: if a write error and a read error fall in the same cycle, err_o is a single pulse (OR). The stat counter still counts 2.
- Simultaneous read and write: both are legal in one cycle. The upstream arbiter normally makes them exclusive, but the block must not rely on that.
- No state machine beyond the pipeline. Stage k shifts to stage k+1 every cycle, and stage RD_LATENCY-1 drives the outputs.

Optional Feature:
- Macro: CTX_MEM_RESPONDER_STATS_EN.
- Defined: adds outputs stat_wr_cnt_o, stat_rd_cnt_o, stat_err_cnt_o (CNT_W bits each) and input stat_clr_i (1 bit).
  - Counters increment on each accepted in-range write, each accepted read, and each error event.
  - Counters saturate at all-ones and reset to 0.
  - stat_clr_i zeroes all three counters synchronously and takes priority over same-cycle increments.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package ctx_mem_pkg holds:
  - typedef ctx_addr_t (logic [31:0]) and ctx_word_t (logic [31:0]).
  - struct ctx_rsp_t {valid, err, data}.
  - localparam CTX_POISON = 32'hDEAD_BEEF.
- Sub-module ctx_mem_rsp_pipe:
  - Parameterised RD_LATENCY shift register of ctx_rsp_t with asynchronous active-high reset clearing valid/err.
  - Reused later by the instruction-side memory model.

Test Plan:
- Write 0x1234_5678 to BASE_ADDR+0x10, then read the same address 3 cycles later -> resp_valid exactly 2 cycles after the request, data 0x1234_5678, err_o 0.
- Same-cycle write 0xA5A5_A5A5 and read at BASE_ADDR+0x20 -> response 0xA5A5_A5A5 (bypass).
- 8 back-to-back reads of consecutive words preloaded 0..7 -> 8 consecutive resp_valid cycles returning 0..7 in order.
- Read at BASE_ADDR-4 -> response 0xDEAD_BEEF with err_o high in the same cycle. Write at BASE_ADDR+4*DEPTH -> err_o pulses the next cycle and no store word changes.
- Assert rst_i with 2 reads in flight -> no resp_valid after reset release; a subsequent read of a previously written word returns 0.
- With CTX_MEM_RESPONDER_STATS_EN and CNT_W=4: 20 reads -> stat_rd_cnt_o saturates at 15; stat_clr_i pulse in the same cycle as a read -> counter reads 0.
